// File: rtl/npu_host_seq.sv
// rtl/npu_host_seq.sv - host sequencer: streams one job image into the NPU, starts it, polls status, reads the result
module npu_host_seq #(
    parameter int IN1_N    = 132,
    parameter int OUT1_M   = 10,
    parameter int RD_LAT   = 2,
    parameter int POLL_MAX = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_start,
    input  logic [15:0] job_base,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] result,
    output logic        src_rd,
    output logic [15:0] src_addr,
    input  logic [31:0] src_data,
    output logic        npu_ena,
    output logic        npu_wea,
    output logic [15:0] npu_addr,
    output logic [31:0] npu_dina,
    input  logic [31:0] npu_douta
);
    // Job image word counts: input vector, FC1 weights, FC2 weights.
    localparam int NI  = IN1_N / 4;
    localparam int NF1 = (OUT1_M * IN1_N + 3) / 4;
    localparam int NF2 = (OUT1_M + 3) / 4;
    localparam int NT  = NI + NF1 + NF2;
    localparam logic [15:0] NI_W   = 16'(NI);
    localparam logic [15:0] NF_END = 16'(NI + NF1);
    localparam logic [15:0] NT_W   = 16'(NT);
    localparam int PW = $clog2(POLL_MAX + 1);
    localparam int RW = $clog2(RD_LAT + 1);
    // Control block: idx 0 is status (bit 0 = done), idx 1 is start on write / result on read.
    localparam logic [15:0] ADDR_STATUS = 16'h5000;
    localparam logic [15:0] ADDR_CTRL   = 16'h5001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_POLL,
        S_RESULT,
        S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         base_q, base_d;
    logic [15:0]         n_q, n_d;
    logic                wr_vld_q, wr_vld_d;
    logic [15:0]         wr_n_q, wr_n_d;
    logic [RD_LAT-1:0]   pend_q, pend_d;
    logic [PW-1:0]       poll_q, poll_d;
    logic [RW-1:0]       res_q, res_d;
    logic [31:0]         result_q, result_d;
    logic                error_q, error_d;

    logic [2:0]          wr_sel;
    logic [15:0]         wr_off;

    // Map the word index of the pending write onto its NPU region and offset.
    always_comb begin
        wr_sel = 3'b000;
        wr_off = wr_n_q;
        if (wr_n_q < NI_W) begin
            wr_sel = 3'b000;
            wr_off = wr_n_q;
        end else if (wr_n_q < NF_END) begin
            wr_sel = 3'b011;
            wr_off = wr_n_q - NI_W;
        end else begin
            wr_sel = 3'b100;
            wr_off = wr_n_q - NF_END;
        end
    end

    // Next-state and bus outputs; the NPU write trails its source read by one cycle.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        n_d      = n_q;
        wr_vld_d = 1'b0;
        wr_n_d   = wr_n_q;
        pend_d   = '0;
        poll_d   = poll_q;
        res_d    = res_q;
        result_d = result_q;
        error_d  = error_q;
        busy     = 1'b0;
        done     = 1'b0;
        src_rd   = 1'b0;
        src_addr = 16'h0000;
        npu_ena  = 1'b0;
        npu_wea  = 1'b0;
        npu_addr = 16'h0000;
        npu_dina = 32'h0;

        if (wr_vld_q) begin
            npu_ena  = 1'b1;
            npu_wea  = 1'b1;
            npu_addr = {1'b0, wr_sel, 12'h000} | (wr_off & 16'h0fff);
            npu_dina = src_data;
        end

        case (state_q)
            S_IDLE: begin
                if (job_start) begin
                    base_d   = job_base;
                    n_d      = 16'h0000;
                    result_d = 32'h0;
                    error_d  = 1'b0;
                    poll_d   = '0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                busy = 1'b1;
                if (n_q < NT_W) begin
                    src_rd   = 1'b1;
                    src_addr = base_q + n_q;
                    wr_vld_d = 1'b1;
                    wr_n_d   = n_q;
                    n_d      = n_q + 16'd1;
                end else begin
                    // This cycle only carries the final write out of the pipeline.
                    state_d = S_START;
                end
            end
            S_START: begin
                busy     = 1'b1;
                npu_ena  = 1'b1;
                npu_wea  = 1'b1;
                npu_addr = ADDR_CTRL;
                npu_dina = 32'h1;
                poll_d   = '0;
                state_d  = S_POLL;
            end
            S_POLL: begin
                busy   = 1'b1;
                pend_d = pend_q << 1;
                if (pend_q[RD_LAT-1] && npu_douta[0]) begin
                    // Done seen: stop polling, drop any responses still in flight.
                    pend_d  = '0;
                    res_d   = '0;
                    state_d = S_RESULT;
                end else if (poll_q == PW'(POLL_MAX)) begin
                    if (pend_q == '0) begin
                        error_d  = 1'b1;
                        result_d = 32'h0;
                        state_d  = S_FIN;
                    end
                end else begin
                    // Done is a one-cycle pulse in the NPU, so a read goes out every cycle.
                    npu_ena  = 1'b1;
                    npu_addr = ADDR_STATUS;
                    pend_d   = (pend_q << 1) | RD_LAT'(1);
                    poll_d   = poll_q + PW'(1);
                end
            end
            S_RESULT: begin
                busy = 1'b1;
                if (res_q == '0) begin
                    npu_ena  = 1'b1;
                    npu_addr = ADDR_CTRL;
                end
                if (res_q == RW'(RD_LAT)) begin
                    result_d = npu_douta;
                    state_d  = S_FIN;
                end else begin
                    res_d = res_q + RW'(1);
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            base_q   <= 16'h0000;
            n_q      <= 16'h0000;
            wr_vld_q <= 1'b0;
            wr_n_q   <= 16'h0000;
            pend_q   <= '0;
            poll_q   <= '0;
            res_q    <= '0;
            result_q <= 32'h0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            n_q      <= n_d;
            wr_vld_q <= wr_vld_d;
            wr_n_q   <= wr_n_d;
            pend_q   <= pend_d;
            poll_q   <= poll_d;
            res_q    <= res_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

    assign error  = error_q;
    assign result = result_q;

endmodule

// File: tb/tb_npu_host_seq.sv
// tb/tb_npu_host_seq.sv - directed bench for npu_host_seq with source memory and NPU models
module tb_npu_host_seq;
    localparam int NI  = 33;
    localparam int NF1 = 330;
    localparam int NF2 = 3;
    localparam int NT  = 366;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {~a, a};
    endfunction

    function automatic logic [15:0] exp_npu_addr(input int n);
        if (n < NI) return 16'(n);
        else if (n < NI + NF1) return 16'h3000 + 16'(n - NI);
        else return 16'h4000 + 16'(n - NI - NF1);
    endfunction

    // ---------------- DUT A: default parameters ----------------
    logic        a_job_start;
    logic [15:0] a_job_base;
    logic        a_busy, a_done, a_error;
    logic [31:0] a_result;
    logic        a_src_rd;
    logic [15:0] a_src_addr;
    logic [31:0] a_src_data;
    logic        a_npu_ena, a_npu_wea;
    logic [15:0] a_npu_addr;
    logic [31:0] a_npu_dina, a_npu_douta;

    npu_host_seq dut_a (
        .clk(clk), .rst(rst), .job_start(a_job_start), .job_base(a_job_base),
        .busy(a_busy), .done(a_done), .error(a_error), .result(a_result),
        .src_rd(a_src_rd), .src_addr(a_src_addr), .src_data(a_src_data),
        .npu_ena(a_npu_ena), .npu_wea(a_npu_wea), .npu_addr(a_npu_addr),
        .npu_dina(a_npu_dina), .npu_douta(a_npu_douta)
    );

    int          a_start_cyc = 0;
    int          a_done_rel  = -1;
    logic [31:0] a_res_val   = 32'h0;
    logic [31:0] a_p0 = 32'h0, a_p1 = 32'h0;

    // Source memory: one cycle read latency; junk when not read.
    always @(posedge clk) a_src_data <= a_src_rd ? mem_word(a_src_addr) : 32'hdeadbeef;

    // NPU model: two-cycle read pipe; done visible only to the status read issued at a_done_rel.
    always @(posedge clk) begin
        a_p0 <= 32'h0000_0001;
        if (a_npu_ena && !a_npu_wea) begin
            if (a_npu_addr == 16'h5000)
                a_p0 <= (cyc - a_start_cyc == a_done_rel) ? 32'h0000_0001 : 32'hffff_fffe;
            else if (a_npu_addr == 16'h5001)
                a_p0 <= a_res_val;
        end
        a_p1 <= a_p0;
    end
    assign a_npu_douta = a_p1;

    int          rd_cyc[$];
    logic [15:0] rd_addr[$];
    int          wr_cyc[$];
    logic [15:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          stw_cyc[$];
    logic [31:0] stw_data[$];
    int          poll_cyc[$];
    int          resrd_cyc[$];
    int          done_cyc[$];
    logic        done_err, done_busy;
    logic [31:0] done_res;

    always @(negedge clk) begin
        if (!rst) begin
            if (a_src_rd) begin
                rd_cyc.push_back(cyc - a_start_cyc);
                rd_addr.push_back(a_src_addr);
            end
            if (a_npu_ena && a_npu_wea) begin
                if (a_npu_addr == 16'h5001) begin
                    stw_cyc.push_back(cyc - a_start_cyc);
                    stw_data.push_back(a_npu_dina);
                end else begin
                    wr_cyc.push_back(cyc - a_start_cyc);
                    wr_addr.push_back(a_npu_addr);
                    wr_data.push_back(a_npu_dina);
                end
            end
            if (a_npu_ena && !a_npu_wea) begin
                if (a_npu_addr == 16'h5000) poll_cyc.push_back(cyc - a_start_cyc);
                else if (a_npu_addr == 16'h5001) resrd_cyc.push_back(cyc - a_start_cyc);
            end
            if (a_done) begin
                done_cyc.push_back(cyc - a_start_cyc);
                done_err  = a_error;
                done_res  = a_result;
                done_busy = a_busy;
            end
        end
    end

    task automatic clear_a();
        rd_cyc.delete(); rd_addr.delete();
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        stw_cyc.delete(); stw_data.delete();
        poll_cyc.delete(); resrd_cyc.delete(); done_cyc.delete();
    endtask

    typedef struct {
        int          n;
        logic [15:0] addr;
    } reg_vec_t;
    reg_vec_t regs[5];

    typedef struct {
        logic [15:0] base;
        int          done_rel;
        logic [23:0] r24;
        logic [31:0] exp_res;
        bit          mid;
    } job_t;
    job_t jobs[4];

    task automatic run_job(input job_t j);
        int d;
        int nr, nw, lp;
        d = j.done_rel;
        @(negedge clk);
        clear_a();
        a_done_rel  = d;
        a_res_val   = {{8{j.r24[23]}}, j.r24};
        a_job_base  = j.base;
        a_job_start = 1'b1;
        a_start_cyc = cyc;
        @(negedge clk);
        a_job_start = 1'b0;
        a_job_base  = 16'haaaa;
        chk("busy_after_accept", {31'b0, a_busy}, 32'h1);
        for (int i = 0; i < 3000 && done_cyc.size() == 0; i++) begin
            @(negedge clk);
            if (j.mid && (cyc - a_start_cyc == 50)) begin
                a_job_start = 1'b1;
                a_job_base  = 16'h7777;
            end else begin
                a_job_start = 1'b0;
            end
        end
        a_job_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("done_count", 32'(done_cyc.size()), 32'd1);

        chk("rd_count", 32'(rd_cyc.size()), 32'(NT));
        nr = (rd_cyc.size() < NT) ? rd_cyc.size() : NT;
        for (int n = 0; n < nr; n++) begin
            chk($sformatf("rd_cyc[%0d]", n), 32'(rd_cyc[n]), 32'(n + 1));
            chk($sformatf("rd_addr[%0d]", n), {16'h0, rd_addr[n]}, {16'h0, 16'(j.base + 16'(n))});
        end
        chk("wr_count", 32'(wr_cyc.size()), 32'(NT));
        nw = (wr_cyc.size() < NT) ? wr_cyc.size() : NT;
        for (int n = 0; n < nw; n++) begin
            chk($sformatf("wr_cyc[%0d]", n), 32'(wr_cyc[n]), 32'(n + 2));
            chk($sformatf("wr_addr[%0d]", n), {16'h0, wr_addr[n]}, {16'h0, exp_npu_addr(n)});
            chk($sformatf("wr_data[%0d]", n), wr_data[n], mem_word(16'(j.base + 16'(n))));
        end
        for (int e = 0; e < 5; e++) begin
            if (regs[e].n < wr_addr.size())
                chk($sformatf("region_n%0d", regs[e].n), {16'h0, wr_addr[regs[e].n]}, {16'h0, regs[e].addr});
            else
                chk($sformatf("region_n%0d_missing", regs[e].n), 32'(wr_addr.size()), 32'(NT));
        end

        chk("start_wr_count", 32'(stw_cyc.size()), 32'd1);
        if (stw_cyc.size() > 0) begin
            chk("start_wr_cyc", 32'(stw_cyc[0]), 32'd368);
            chk("start_wr_data", stw_data[0], 32'h1);
        end

        if (poll_cyc.size() > 0) begin
            lp = poll_cyc[poll_cyc.size() - 1];
            chk("poll_first", 32'(poll_cyc[0]), 32'd369);
            chk("poll_gapless", 32'(poll_cyc.size()), 32'(lp - poll_cyc[0] + 1));
            chk("poll_last_in_window", {31'b0, (lp == d + 1) || (lp == d + 2)}, 32'h1);
        end else begin
            chk("poll_count", 32'(poll_cyc.size()), 32'(d - 369 + 2));
        end

        chk("result_rd_count", 32'(resrd_cyc.size()), 32'd1);
        if (resrd_cyc.size() > 0) chk("result_rd_cyc", 32'(resrd_cyc[0]), 32'(d + 3));
        if (done_cyc.size() > 0) begin
            chk("done_cyc", 32'(done_cyc[0]), 32'(d + 6));
            chk("done_error", {31'b0, done_err}, 32'h0);
            chk("done_result", done_res, j.exp_res);
            chk("done_busy", {31'b0, done_busy}, 32'h0);
        end
        chk("result_held", a_result, j.exp_res);
    endtask

    task automatic reset_mid_load();
        @(negedge clk);
        clear_a();
        a_done_rel  = -1;
        a_job_base  = 16'h0300;
        a_job_start = 1'b1;
        a_start_cyc = cyc;
        @(negedge clk);
        a_job_start = 1'b0;
        repeat (99) @(negedge clk);
        chk("pre_rst_src_rd", {31'b0, a_src_rd}, 32'h1);
        chk("pre_rst_src_addr", {16'h0, a_src_addr}, 32'h0000_0363);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", {31'b0, a_busy}, 32'h0);
        chk("rst_src_rd", {31'b0, a_src_rd}, 32'h0);
        chk("rst_src_addr", {16'h0, a_src_addr}, 32'h0);
        chk("rst_npu_ena", {31'b0, a_npu_ena}, 32'h0);
        chk("rst_npu_addr", {16'h0, a_npu_addr}, 32'h0);
        chk("rst_npu_dina", a_npu_dina, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {31'b0, a_busy}, 32'h0);
        repeat (5) @(negedge clk);
        chk("no_done_after_rst", 32'(done_cyc.size()), 32'd0);
    endtask

    // ---------------- DUT B: tiny image, POLL_MAX=8 ----------------
    logic        b_job_start;
    logic [15:0] b_job_base;
    logic        b_busy, b_done, b_error;
    logic [31:0] b_result;
    logic        b_src_rd;
    logic [15:0] b_src_addr;
    logic [31:0] b_src_data;
    logic        b_npu_ena, b_npu_wea;
    logic [15:0] b_npu_addr;
    logic [31:0] b_npu_dina, b_npu_douta;

    npu_host_seq #(.IN1_N(4), .OUT1_M(1), .RD_LAT(2), .POLL_MAX(8)) dut_b (
        .clk(clk), .rst(rst), .job_start(b_job_start), .job_base(b_job_base),
        .busy(b_busy), .done(b_done), .error(b_error), .result(b_result),
        .src_rd(b_src_rd), .src_addr(b_src_addr), .src_data(b_src_data),
        .npu_ena(b_npu_ena), .npu_wea(b_npu_wea), .npu_addr(b_npu_addr),
        .npu_dina(b_npu_dina), .npu_douta(b_npu_douta)
    );

    int          b_start_cyc = 0;
    int          b_done_rel  = -1;
    logic [31:0] b_res_val   = 32'h0;
    logic [31:0] b_p0 = 32'h0, b_p1 = 32'h0;
    int          b_polls = 0;
    int          b_done_n = 0;
    logic        b_err_seen;
    logic [31:0] b_res_seen;

    always @(posedge clk) b_src_data <= b_src_rd ? mem_word(b_src_addr) : 32'hdeadbeef;

    always @(posedge clk) begin
        b_p0 <= 32'h0000_0001;
        if (b_npu_ena && !b_npu_wea) begin
            if (b_npu_addr == 16'h5000)
                b_p0 <= (cyc - b_start_cyc == b_done_rel) ? 32'h0000_0001 : 32'hffff_fffe;
            else if (b_npu_addr == 16'h5001)
                b_p0 <= b_res_val;
        end
        b_p1 <= b_p0;
    end
    assign b_npu_douta = b_p1;

    always @(negedge clk) begin
        if (!rst) begin
            if (b_npu_ena && !b_npu_wea && b_npu_addr == 16'h5000) b_polls++;
            if (b_done) begin
                b_done_n++;
                b_err_seen = b_error;
                b_res_seen = b_result;
            end
        end
    end

    task automatic run_b(input int done_rel, input logic [31:0] res_val);
        @(negedge clk);
        b_polls     = 0;
        b_done_n    = 0;
        b_done_rel  = done_rel;
        b_res_val   = res_val;
        b_job_base  = 16'h1000;
        b_job_start = 1'b1;
        b_start_cyc = cyc;
        @(negedge clk);
        b_job_start = 1'b0;
        for (int i = 0; i < 300 && b_done_n == 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("b_done_count", 32'(b_done_n), 32'd1);
    endtask

    initial begin
        regs[0] = '{32,  16'h0020};
        regs[1] = '{33,  16'h3000};
        regs[2] = '{362, 16'h3149};
        regs[3] = '{363, 16'h4000};
        regs[4] = '{365, 16'h4002};

        jobs[0] = '{16'h0100, 500, 24'hffff9c, 32'hffffff9c, 1'b0};
        jobs[1] = '{16'h0000, 369, 24'h000123, 32'h00000123, 1'b0};
        jobs[2] = '{16'hfff0, 420, 24'h7fffff, 32'h007fffff, 1'b0};
        jobs[3] = '{16'h0200, 380, 24'h800000, 32'hff800000, 1'b1};

        rst         = 1'b1;
        a_job_start = 1'b0;
        a_job_base  = 16'h0;
        b_job_start = 1'b0;
        b_job_base  = 16'h0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'b0, a_busy}, 32'h0);
        chk("reset_done", {31'b0, a_done}, 32'h0);
        chk("reset_error", {31'b0, a_error}, 32'h0);
        chk("reset_result", a_result, 32'h0);
        chk("reset_src_rd", {31'b0, a_src_rd}, 32'h0);
        chk("reset_src_addr", {16'h0, a_src_addr}, 32'h0);
        chk("reset_npu_ena", {31'b0, a_npu_ena}, 32'h0);
        chk("reset_npu_wea", {31'b0, a_npu_wea}, 32'h0);
        chk("reset_npu_addr", {16'h0, a_npu_addr}, 32'h0);
        chk("reset_npu_dina", a_npu_dina, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        reset_mid_load();

        for (int k = 0; k < 4; k++) run_job(jobs[k]);

        run_b(10, 32'h12345678);
        chk("b_ok_error", {31'b0, b_err_seen}, 32'h0);
        chk("b_ok_result", b_res_seen, 32'h12345678);

        run_b(-1, 32'h12345678);
        chk("b_timeout_polls", 32'(b_polls), 32'd8);
        chk("b_timeout_error", {31'b0, b_err_seen}, 32'h1);
        chk("b_timeout_result", b_res_seen, 32'h0);
        @(negedge clk);
        chk("b_error_held", {31'b0, b_error}, 32'h1);
        chk("b_idle_after", {31'b0, b_busy}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/npu_host_seq.md
NPU_HOST_SEQ -- requirements
Module: npu_host_seq

Interface
REQ-001 Parameter IN1_N, default 132, input-vector length in int8 elements; SHALL be a multiple of 4.
REQ-002 Parameter OUT1_M, default 10, FC1 neuron count.
REQ-003 Parameter RD_LAT, default 2, cycles from NPU read request to valid npu_douta.
REQ-004 Parameter POLL_MAX, default 4096, maximum status reads before timeout.
REQ-005 Clock and reset: clk; reset rst, asynchronous, active-high.
REQ-006 clk  in  1  clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 job_start  in  1  one-cycle request to run one inference.
REQ-009 job_base  in  16  source word address of the job image, sampled with job_start.
REQ-010 busy  out  1  high from job acceptance until the done pulse.
REQ-011 done  out  1  one-cycle pulse at job end.
REQ-012 error  out  1  timeout flag, valid with done, held until next accepted job.
REQ-013 result  out  32  NPU result word, held until next accepted job.
REQ-014 src_rd / src_addr / src_data  out 1 / out 16 / in 32  source memory read port; src_data valid exactly 1 cycle after src_rd.
REQ-015 npu_ena / npu_wea / npu_addr / npu_dina  out 1 / 1 / 16 / 32  NPU bus request; npu_addr = {1'b0, sel[2:0], idx[11:0]}.
REQ-016 npu_douta  in  32  NPU read data.

Function
REQ-017 Word counts: NI = IN1_N/4; NF1 = ceil(OUT1_M*IN1_N/4); NF2 = ceil(OUT1_M/4); total NT = NI+NF1+NF2 (366 at defaults).
REQ-018 Source image layout: words job_base+0..NI-1 input, next NF1 fc1, next NF2 fc2; src_addr wraps modulo 2^16.
REQ-019 States: IDLE, LOAD, START, POLL, RESULT, FIN.
REQ-020 IDLE: job_start accepted only here; job_start in any other state ignored; busy rises the cycle after acceptance.
REQ-021 LOAD: one src_rd per cycle, src_addr = job_base+n for n = 0..NT-1, starting the cycle after acceptance.
REQ-022 Word n SHALL be written to the NPU exactly 1 cycle after its src_rd (npu_ena=1, npu_wea=1, npu_dina=src_data); throughput 1 word/cycle, no bubbles.
REQ-023 Region mapping: n<NI -> sel 000, idx n; next NF1 -> sel 011, idx n-NI; last NF2 -> sel 100, idx n-NI-NF1.
REQ-024 START: the cycle after the last weight write, one write sel 101, idx 1, dina 32'h1.
REQ-025 POLL: from the next cycle, status reads (ena=1, wea=0, sel 101, idx 0) issued on every consecutive cycle; NPU done is visible for a single cycle only, so no gaps are permitted.
REQ-026 Each poll response sampled RD_LAT cycles after its request; first response with bit 0 = 1 ends polling; no further status requests issue after that cycle; in-flight responses discarded.
REQ-027 RESULT: one read sel 101, idx 1; result captured from npu_douta RD_LAT cycles later.
REQ-028 FIN: done=1 for one cycle, busy=0 in the same cycle, return to IDLE; next job_start accepted in the following cycle.
REQ-029 Timeout: if POLL_MAX requests issue with no done response after draining all RD_LAT in-flight responses, enter FIN with error=1, result=0, and skip RESULT.
REQ-030 npu_ena=0, src_rd=0 in every cycle not listed above; npu_dina=0 whenever npu_wea=0.

Reset
REQ-031 On rst: state IDLE; busy, done, error, src_rd, npu_ena, npu_wea = 0; result, src_addr, npu_addr, npu_dina = 0; all counters = 0.
REQ-032 rst mid-job abandons the job without a done pulse; the first cycle after release is IDLE.

Verification
REQ-033 Full job with the NPU model, job_base=0x0100, job_start at cycle 0 -> src_rd at cycles 1..366 with src_addr 0x0100..0x026D; NPU writes at cycles 2..367; start write at 368; polls from 369; result matches the golden model; one done pulse with error=0.
REQ-034 Region boundary -> write n=32 at addr 0x0020; n=33 at 0x3000; n=362 at 0x3149; n=363 at 0x4000; n=365 at 0x4002.
REQ-035 Single-cycle NPU done set at cycle 500 -> detected; exactly one result read; result = sign-extended 24-bit value, e.g. 0xFFFFFF9C for -100.
REQ-036 NPU never sets done, POLL_MAX=8 -> exactly 8 status reads; done with error=1, result=0.
REQ-037 job_start pulsed while busy -> ignored; src_addr sequence continues unchanged.
REQ-038 rst asserted at cycle 100 of LOAD -> all outputs 0 immediately; later job_start with job_base=0 -> src_addr restarts at 0x0000.
